// File: rtl/accel_filter.sv
// rtl/accel_filter.sv - per-channel moving-average conditioning stage with saturating output
module accel_filter #(
    parameter int NCH        = 3,
    parameter int IN_W       = 16,
    parameter int OUT_W      = 10,
    parameter int LOG2_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [NCH*IN_W-1:0]   in_data,
    input  logic                  freeze,
    output logic [NCH*OUT_W-1:0]  out_data,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  primed,
    output logic                  overrun
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SUM_W = IN_W + LOG2_DEPTH;
    localparam int IDX_W = (LOG2_DEPTH > 0) ? LOG2_DEPTH : 1;
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNT_W = LOG2_DEPTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_UPD, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic [IDX_W-1:0]         wr_idx_q, wr_idx_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [NCH*IN_W-1:0]      in_q;
    logic signed [IN_W-1:0]   old_q;
    logic signed [IN_W-1:0]   buf_q [NCH][DEPTH];
    logic signed [SUM_W-1:0]  sum_q [NCH];
    logic [NCH*OUT_W-1:0]     out_q, out_next;
    logic                     out_valid_q, overrun_q, primed_q;

    logic signed [IN_W-1:0]   new_s;
    logic signed [SUM_W:0]    upd_sum;

    assign new_s   = in_q[ch_q*IN_W +: IN_W];
    // One guard bit so the add/subtract cannot wrap before the result settles back into SUM_W.
    assign upd_sum = (SUM_W+1)'(sum_q[ch_q]) + (SUM_W+1)'(new_s) - (SUM_W+1)'(old_q);

    assign wr_idx_d = (LOG2_DEPTH == 0) ? '0 : wr_idx_q + IDX_W'(1);
    assign cnt_d    = (cnt_q == CNT_W'(DEPTH)) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_RD;
                    ch_d    = '0;
                end
            end
            S_RD:   state_d = S_UPD;
            S_UPD: begin
                if (ch_q == CH_W'(NCH - 1)) begin
                    state_d = S_DONE;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = S_RD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic signed [SUM_W-1:0] shifted;
        logic signed [IN_W-1:0]  avg;
        assign shifted = sum_q[c] >>> LOG2_DEPTH;
        assign avg     = shifted[IN_W-1:0];
        if (OUT_W < IN_W) begin : g_sat
            localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
            localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;
            assign out_next[c*OUT_W +: OUT_W] = (avg > MAX_V) ? MAX_V[OUT_W-1:0] :
                                                (avg < MIN_V) ? MIN_V[OUT_W-1:0] :
                                                avg[OUT_W-1:0];
        end else begin : g_ext
            assign out_next[c*OUT_W +: OUT_W] = OUT_W'(avg);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            wr_idx_q    <= '0;
            cnt_q       <= '0;
            in_q        <= '0;
            old_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            primed_q    <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                sum_q[c] <= '0;
                for (int d = 0; d < DEPTH; d++) begin
                    buf_q[c][d] <= '0;
                end
            end
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            out_valid_q <= 1'b0;
            if (in_valid && state_q != S_IDLE) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        in_q <= in_data;
                    end
                end
                S_RD:   old_q <= buf_q[ch_q][wr_idx_q];
                S_UPD: begin
                    sum_q[ch_q]           <= upd_sum[SUM_W-1:0];
                    buf_q[ch_q][wr_idx_q] <= new_s;
                end
                S_DONE: begin
                    wr_idx_q <= wr_idx_d;
                    cnt_q    <= cnt_d;
                    if (cnt_d == CNT_W'(DEPTH)) begin
                        primed_q <= 1'b1;
                    end
                    // Sums keep tracking while frozen; only the visible result is held.
                    if (!freeze) begin
                        out_q       <= out_next;
                        out_valid_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data  = out_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != S_IDLE);
    assign primed    = primed_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_accel_filter.sv
// tb/tb_accel_filter.sv - scoreboard bench for accel_filter against a windowed-average model
module tb_accel_filter;
    localparam int NCH = 3, IN_W = 16, OUT_W = 10, L2 = 2, D = 4, LAT = 2*NCH + 1;

    logic                 clk = 1'b0;
    logic                 rst, in_valid, freeze;
    logic [NCH*IN_W-1:0]  in_data;
    logic [NCH*OUT_W-1:0] out_data;
    logic                 out_valid, busy, primed, overrun;

    accel_filter #(.NCH(NCH), .IN_W(IN_W), .OUT_W(OUT_W), .LOG2_DEPTH(L2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .freeze(freeze),
        .out_data(out_data), .out_valid(out_valid), .busy(busy), .primed(primed), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [NCH*OUT_W-1:0] data;
        bit                   primed;
        int                   due;
    } exp_t;

    exp_t                 expq[$];
    logic [NCH*OUT_W-1:0] hold_exp;
    int                   hist[NCH][$];
    int                   n_acc, next_free;
    bit                   ovr_exp;
    int                   n_pass = 0, n_total = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, req, cyc);
    endtask

    function automatic int sat(input int v);
        if (v > 511) return 511;
        if (v < -512) return -512;
        return v;
    endfunction

    function automatic int fdiv(input int s);
        int q;
        q = s / D;
        if ((s % D) != 0 && s < 0) q--;
        return q;
    endfunction

    task automatic send(input logic [NCH*IN_W-1:0] d, input bit frz);
        int k, sum;
        exp_t e;
        logic signed [IN_W-1:0] s;
        logic [31:0] tmp;
        @(negedge clk); #1;
        k = cyc + 1;
        in_valid = 1'b1;
        in_data  = d;
        if (k >= next_free) begin
            freeze    = frz;
            next_free = k + LAT + 1;
            n_acc++;
            e.data = '0;
            for (int c = 0; c < NCH; c++) begin
                s = d[c*IN_W +: IN_W];
                hist[c].push_back(int'(s));
                if (hist[c].size() > D) void'(hist[c].pop_front());
                sum = 0;
                foreach (hist[c][i]) sum += hist[c][i];
                tmp = sat(fdiv(sum));
                e.data[c*OUT_W +: OUT_W] = tmp[OUT_W-1:0];
            end
            e.primed = (n_acc >= D);
            e.due    = k + LAT;
            if (!frz) expq.push_back(e);
        end else begin
            ovr_exp = 1'b1;
        end
        @(negedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int t = 0;
        while ((expq.size() > 0 || cyc < next_free) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending", expq.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        freeze   = 1'b0;
        expq.delete();
        hold_exp = '0;
        for (int c = 0; c < NCH; c++) hist[c].delete();
        n_acc     = 0;
        next_free = 0;
        ovr_exp   = 1'b0;
        #1;
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_primed", primed, 0);
        check("rst_overrun", overrun, 0);
        @(negedge clk); #1;
        rst = 1'b1;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            if (out_valid) begin
                if (expq.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e = expq.pop_front();
                    check("out_data", out_data, e.data);
                    check("primed", primed, e.primed);
                    check("latency", cyc, e.due);
                    hold_exp = e.data;
                end
            end else begin
                check("hold", out_data, hold_exp);
                if (expq.size() > 0 && expq[0].due < cyc) begin
                    check("missed_valid", 0, 1);
                    void'(expq.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NCH*IN_W-1:0] rd;
        rst = 1'b0; in_valid = 1'b0; freeze = 1'b0; in_data = '0;
        hold_exp = '0; n_acc = 0; next_free = 0; ovr_exp = 1'b0;

        do_reset();
        repeat (4) begin
            send({3{16'd100}}, 1'b0);
            idle(8);
        end
        drain();
        check("ramp_primed", primed, 1);
        check("ramp_overrun", overrun, 0);

        do_reset();
        repeat (4) begin send({16'h0000, 16'h8000, 16'h7FFF}, 1'b0); idle(7); end
        repeat (4) begin send({16'hFFFF, 16'hFED4, 16'd300}, 1'b0); idle(7); end
        drain();

        do_reset();
        repeat (4) begin send({32'd0, 16'h0004}, 1'b0); idle(7); end
        repeat (4) begin send({32'd0, 16'd400}, 1'b0); idle(7); end
        send({32'd0, 16'd0}, 1'b0);
        drain();

        do_reset();
        send({3{16'd100}}, 1'b0); idle(7);
        send({3{16'd100}}, 1'b1); idle(7);
        send({3{16'd100}}, 1'b1);
        drain();
        check("freeze_hold", out_data, {3{10'd25}});
        send({3{16'd100}}, 1'b0);
        drain();
        check("freeze_resume", out_data, {3{10'd100}});

        do_reset();
        send({3{16'd100}}, 1'b0);
        idle(1);
        send({3{16'd500}}, 1'b0);
        drain();
        check("overrun_set", overrun, ovr_exp);
        idle(3);
        check("overrun_sticky", overrun, 1);

        send({3{16'd100}}, 1'b0);
        idle(2);
        check("busy_mid", busy, 1);
        do_reset();
        send({3{16'd100}}, 1'b0);
        drain();
        check("post_rst_primed", primed, 0);

        do_reset();
        for (int i = 0; i < 40; i++) begin
            for (int c = 0; c < NCH; c++) rd[c*IN_W +: IN_W] = IN_W'($urandom);
            send(rd, $urandom_range(0, 3) == 0);
            idle($urandom_range(0, 10));
        end
        drain();
        check("rand_overrun", overrun, ovr_exp);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
